// File: rtl/store_buffer_pkg.sv
// Shared constants and the entry type for the store buffer.
package store_buffer_pkg;

  localparam int          SB_DEPTH_DEFAULT = 4;
  localparam logic [31:0] SB_LED_ADDR      = 32'h0000_2000;

  localparam int SM_SIGNED = 3;
  localparam int SM_WORD   = 2;
  localparam int SM_HALF   = 1;
  localparam int SM_BYTE   = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sign_mask;
  } entry_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// Entry storage, wrapping pointers and occupancy count for the store buffer.
module store_buffer_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_push,
  input  entry_t                        i_entry,
  input  logic                          i_pop,
  output entry_t                        o_head,
  output logic [$clog2(DEPTH):0]        o_count,
  output logic [DEPTH-1:0]              o_valid,
  output logic [DEPTH-1:0][29:0]        o_word_addr
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload carries no reset; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_entry;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [PTR_W-1:0] w_off;
    assign w_off          = PTR_W'(g) - r_rd_ptr;
    assign o_valid[g]     = ({1'b0, w_off} < r_count);
    assign o_word_addr[g] = r_mem[g].addr[31:2];
  end

  assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/store_buffer.sv
// Store buffer between pipeline and data memory: loads bypass, stores drain in order.
// Optional STORE_BUFFER_STATS_EN adds a saturating stall-cycle counter output.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_write_data,
  input  logic        cpu_memwrite,
  input  logic        cpu_memread,
  input  logic [3:0]  cpu_sign_mask,
  output logic        cpu_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic        mem_clk_stall
`ifdef STORE_BUFFER_STATS_EN
  ,
  output logic [31:0] stall_count
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  entry_t                 w_head;
  entry_t                 w_push_entry;
  logic [CNT_W-1:0]       w_count;
  logic [DEPTH-1:0]       w_valid;
  logic [DEPTH-1:0]       w_match;
  logic [DEPTH-1:0][29:0] w_word_addr;
  logic                   w_is_store;
  logic                   w_full;
  logic                   w_hazard;
  logic                   w_load_pass;
  logic                   w_drain;
  logic                   w_push;

  assign w_push_entry = '{addr: cpu_addr, data: cpu_write_data, sign_mask: cpu_sign_mask};

  store_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_entry     (w_push_entry),
    .i_pop       (w_drain),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_valid     (w_valid),
    .o_word_addr (w_word_addr)
  );

  // Hazard is a word-granular match against every live entry.
  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    assign w_match[g] = w_valid[g] & (w_word_addr[g] == cpu_addr[31:2]);
  end

  // A simultaneous read+write request is a load; its store half is dropped.
  assign w_is_store  = cpu_memwrite & ~cpu_memread;
  assign w_full      = (w_count == CNT_W'(DEPTH));
  assign w_hazard    = cpu_memread & (|w_match);
  assign w_load_pass = ~reset & cpu_memread & ~w_hazard;
  assign w_drain     = ~reset & ~w_load_pass & (w_count != '0) & ~mem_clk_stall;
  assign w_push      = ~reset & w_is_store & ~w_full;
  assign cpu_stall   = ~reset & (w_hazard | (w_is_store & w_full));

  always_comb begin
    mem_addr       = w_head.addr;
    mem_write_data = w_head.data;
    mem_sign_mask  = w_head.sign_mask;
    mem_memwrite   = w_drain;
    mem_memread    = w_load_pass;
    if (w_load_pass) begin
      mem_addr      = cpu_addr;
      mem_sign_mask = cpu_sign_mask;
    end
  end

`ifdef STORE_BUFFER_STATS_EN
  logic [31:0] r_stall_count;

  always_ff @(posedge clk) begin
    if (reset)
      r_stall_count <= '0;
    else if (cpu_stall && (r_stall_count != '1))
      r_stall_count <= r_stall_count + 32'd1;
  end

  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus randomized model compare.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_write_data;
  logic        cpu_memwrite;
  logic        cpu_memread;
  logic [3:0]  cpu_sign_mask;
  logic        cpu_stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [3:0]  mem_sign_mask;
  logic        mem_clk_stall;
`ifdef STORE_BUFFER_STATS_EN
  logic [31:0] stall_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_addr       (cpu_addr),
    .cpu_write_data (cpu_write_data),
    .cpu_memwrite   (cpu_memwrite),
    .cpu_memread    (cpu_memread),
    .cpu_sign_mask  (cpu_sign_mask),
    .cpu_stall      (cpu_stall),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_memwrite   (mem_memwrite),
    .mem_memread    (mem_memread),
    .mem_sign_mask  (mem_sign_mask),
    .mem_clk_stall  (mem_clk_stall)
`ifdef STORE_BUFFER_STATS_EN
    ,
    .stall_count    (stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    cpu_memwrite   = wr;
    cpu_memread    = rd;
    cpu_addr       = a;
    cpu_write_data = d;
    cpu_sign_mask  = m;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_clk_stall = 1'b0;
    drive(1'b1, 1'b0, 32'h1000, 32'h1, 4'h4);
    tick();
    drive(1'b1, 1'b1, 32'h1000, 32'h1, 4'h4);
    if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %0b exp 0", cpu_stall); end
    n_tests++;
    if (mem_memwrite !== 1'b0) begin n_fail++; $display("FAIL rst_memwrite got %0b exp 0", mem_memwrite); end
    n_tests++;
    if (mem_memread !== 1'b0) begin n_fail++; $display("FAIL rst_memread got %0b exp 0", mem_memread); end
    n_tests++;
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    if (mem_memwrite !== 1'b0 || mem_addr !== 32'h0) begin
      n_fail++; $display("FAIL rst_empty got we=%0b addr=%h exp we=0 addr=0", mem_memwrite, mem_addr);
    end
    n_tests++;
  endtask

  task automatic test_single_store();
    mem_clk_stall = 1'b0;
    drive(1'b1, 1'b0, 32'h1004, 32'hDEADBEEF, 4'b0100);
    if (cpu_stall !== 1'b0 || mem_memwrite !== 1'b0) begin
      n_fail++; $display("FAIL single_push got stall=%0b we=%0b exp 0 0", cpu_stall, mem_memwrite);
    end
    n_tests++;
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    if (mem_memwrite !== 1'b1 || mem_addr !== 32'h1004 || mem_write_data !== 32'hDEADBEEF || mem_sign_mask !== 4'b0100) begin
      n_fail++; $display("FAIL single_drain got we=%0b addr=%h data=%h sm=%h exp 1 00001004 deadbeef 4",
                         mem_memwrite, mem_addr, mem_write_data, mem_sign_mask);
    end
    n_tests++;
    tick();
    if (mem_memwrite !== 1'b0 || mem_addr !== 32'h0) begin
      n_fail++; $display("FAIL single_empty got we=%0b addr=%h exp 0 0", mem_memwrite, mem_addr);
    end
    n_tests++;
  endtask

  task automatic test_full();
    mem_clk_stall = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, 32'h3000 + 32'(4 * i), 32'h100 + 32'(i), 4'b0100);
      if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL full_fill%0d got stall=%0b exp 0", i, cpu_stall); end
      n_tests++;
      tick();
    end
    drive(1'b1, 1'b0, 32'h3010, 32'h104, 4'b0100);
    if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL full_stall got %0b exp 1", cpu_stall); end
    n_tests++;
    tick();
    mem_clk_stall = 1'b0;
    #1;
    if (cpu_stall !== 1'b1 || mem_memwrite !== 1'b1 || mem_addr !== 32'h3000) begin
      n_fail++; $display("FAIL full_popcycle got stall=%0b we=%0b addr=%h exp 1 1 00003000", cpu_stall, mem_memwrite, mem_addr);
    end
    n_tests++;
    tick();
    if (cpu_stall !== 1'b0 || mem_memwrite !== 1'b1 || mem_addr !== 32'h3004) begin
      n_fail++; $display("FAIL full_accept got stall=%0b we=%0b addr=%h exp 0 1 00003004", cpu_stall, mem_memwrite, mem_addr);
    end
    n_tests++;
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int i = 2; i <= DEPTH; i++) begin
      if (mem_memwrite !== 1'b1 || mem_addr !== 32'h3000 + 32'(4 * i) || mem_write_data !== 32'h100 + 32'(i)) begin
        n_fail++; $display("FAIL full_order%0d got we=%0b addr=%h data=%h exp 1 %h %h", i, mem_memwrite,
                           mem_addr, mem_write_data, 32'h3000 + 32'(4 * i), 32'h100 + 32'(i));
      end
      n_tests++;
      tick();
    end
    if (mem_memwrite !== 1'b0) begin n_fail++; $display("FAIL full_drained got we=%0b exp 0", mem_memwrite); end
    n_tests++;
  endtask

  task automatic test_hazard();
    mem_clk_stall = 1'b1;
    drive(1'b1, 1'b0, 32'h1008, 32'h55, 4'b0100);
    tick();
    drive(1'b0, 1'b1, 32'h100A, 32'h0, 4'b1010);
    for (int i = 0; i < 2; i++) begin
      if (cpu_stall !== 1'b1 || mem_memread !== 1'b0) begin
        n_fail++; $display("FAIL hazard_hold%0d got stall=%0b rd=%0b exp 1 0", i, cpu_stall, mem_memread);
      end
      n_tests++;
      tick();
    end
    mem_clk_stall = 1'b0;
    #1;
    if (cpu_stall !== 1'b1 || mem_memwrite !== 1'b1 || mem_addr !== 32'h1008 || mem_memread !== 1'b0) begin
      n_fail++; $display("FAIL hazard_drain got stall=%0b we=%0b rd=%0b addr=%h exp 1 1 0 00001008",
                         cpu_stall, mem_memwrite, mem_memread, mem_addr);
    end
    n_tests++;
    tick();
    if (cpu_stall !== 1'b0 || mem_memread !== 1'b1 || mem_memwrite !== 1'b0 || mem_addr !== 32'h100A || mem_sign_mask !== 4'b1010) begin
      n_fail++; $display("FAIL hazard_load got stall=%0b rd=%0b we=%0b addr=%h sm=%h exp 0 1 0 0000100a a",
                         cpu_stall, mem_memread, mem_memwrite, mem_addr, mem_sign_mask);
    end
    n_tests++;
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic test_no_hazard();
    mem_clk_stall = 1'b1;
    drive(1'b1, 1'b0, 32'h1200, 32'hA0, 4'b0100);
    tick();
    drive(1'b1, 1'b0, 32'h1204, 32'hA1, 4'b0100);
    tick();
    mem_clk_stall = 1'b0;
    drive(1'b0, 1'b1, 32'h1100, 32'h0, 4'b0100);
    if (cpu_stall !== 1'b0 || mem_memread !== 1'b1 || mem_memwrite !== 1'b0 || mem_addr !== 32'h1100) begin
      n_fail++; $display("FAIL nohaz_load got stall=%0b rd=%0b we=%0b addr=%h exp 0 1 0 00001100",
                         cpu_stall, mem_memread, mem_memwrite, mem_addr);
    end
    n_tests++;
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int i = 0; i < 2; i++) begin
      if (mem_memwrite !== 1'b1 || mem_memread !== 1'b0 || mem_addr !== 32'h1200 + 32'(4 * i)) begin
        n_fail++; $display("FAIL nohaz_resume%0d got we=%0b rd=%0b addr=%h exp 1 0 %h", i, mem_memwrite,
                           mem_memread, mem_addr, 32'h1200 + 32'(4 * i));
      end
      n_tests++;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    mem_clk_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h1400 + 32'(4 * i), 32'hB0 + 32'(i), 4'b0100);
      tick();
    end
    mem_clk_stall = 1'b0;
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    if (mem_memwrite !== 1'b0) begin n_fail++; $display("FAIL rstmid_edge got we=%0b exp 0", mem_memwrite); end
    n_tests++;
    tick();
    reset = 1'b0;
    #1;
    if (mem_memwrite !== 1'b0 || cpu_stall !== 1'b0 || mem_addr !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_after got we=%0b stall=%0b addr=%h exp 0 0 0", mem_memwrite, cpu_stall, mem_addr);
    end
    n_tests++;
    drive(1'b0, 1'b1, 32'h1404, 32'h0, 4'b0100);
    if (cpu_stall !== 1'b0 || mem_memread !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_invalid got stall=%0b rd=%0b exp 0 1", cpu_stall, mem_memread);
    end
    n_tests++;
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } ent_t;

  task automatic test_random();
    ent_t        q[$];
    logic [31:0] pool [5];
    logic        wr, rd, rs, hz, st, e_stall, e_we, e_rd;
    logic [31:0] a, e_addr, e_data;
    logic [3:0]  e_sm;
    int          sz;
    pool = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h2000};
    do_reset();
    for (int c = 0; c < 400; c++) begin
      wr = 1'($urandom_range(0, 1));
      rd = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 59) == 0);
      a  = pool[$urandom_range(0, 4)] | 32'($urandom_range(0, 3));
      mem_clk_stall = ($urandom_range(0, 9) < 4);
      reset = rs;
      drive(wr, rd, a, $urandom, 4'($urandom_range(0, 15)));
      hz = 1'b0;
      foreach (q[i]) if (q[i].a[31:2] == a[31:2]) hz = rd;
      st = wr && !rd;
      sz = q.size();
      e_addr = (sz > 0) ? q[0].a : 32'h0;
      e_data = (sz > 0) ? q[0].d : 32'h0;
      e_sm   = (sz > 0) ? q[0].m : 4'h0;
      if (rs) begin
        e_stall = 1'b0; e_we = 1'b0; e_rd = 1'b0;
      end else begin
        e_stall = hz || (st && sz == DEPTH);
        e_rd    = rd && !hz;
        e_we    = !e_rd && sz > 0 && !mem_clk_stall;
        if (e_rd) begin e_addr = a; e_sm = cpu_sign_mask; end
      end
      if (cpu_stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall c=%0d got %0b exp %0b", c, cpu_stall, e_stall); end
      n_tests++;
      if (mem_memwrite !== e_we || mem_memread !== e_rd) begin
        n_fail++; $display("FAIL rnd_ctrl c=%0d got we=%0b rd=%0b exp %0b %0b", c, mem_memwrite, mem_memread, e_we, e_rd);
      end
      n_tests++;
      if (!rs) begin
        if (mem_addr !== e_addr || mem_sign_mask !== e_sm || (!e_rd && mem_write_data !== e_data)) begin
          n_fail++; $display("FAIL rnd_data c=%0d got addr=%h data=%h sm=%h exp %h %h %h", c, mem_addr,
                             mem_write_data, mem_sign_mask, e_addr, e_data, e_sm);
        end
        n_tests++;
      end
      if (rs) q.delete();
      else begin
        if (e_we) void'(q.pop_front());
        if (st && sz < DEPTH) q.push_back('{a: a, d: cpu_write_data, m: cpu_sign_mask});
      end
      tick();
    end
    reset = 1'b0;
    mem_clk_stall = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    do_reset();
  endtask

`ifdef STORE_BUFFER_STATS_EN
  task automatic test_stats();
    do_reset();
    mem_clk_stall = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, 32'h5000 + 32'(4 * i), 32'(i), 4'b0100);
      tick();
    end
    drive(1'b1, 1'b0, 32'h5100, 32'h9, 4'b0100);
    for (int i = 0; i < 3; i++) tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    if (stall_count !== 32'd3) begin n_fail++; $display("FAIL stats_count got %0d exp 3", stall_count); end
    n_tests++;
    do_reset();
    #1;
    if (stall_count !== 32'd0) begin n_fail++; $display("FAIL stats_reset got %0d exp 0", stall_count); end
    n_tests++;
    mem_clk_stall = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1;
    mem_clk_stall = 1'b0;
    cpu_addr = '0;
    cpu_write_data = '0;
    cpu_memwrite = 1'b0;
    cpu_memread = 1'b0;
    cpu_sign_mask = '0;
    #1;
    test_reset();
    test_single_store();
    test_full();
    test_hazard();
    test_no_hazard();
    test_reset_mid();
    test_random();
`ifdef STORE_BUFFER_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of store entries (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports cpu_addr (in 32), cpu_write_data (in 32), cpu_memwrite (in 1), cpu_memread (in 1) and cpu_sign_mask (in 4), the pipeline memory request.
REQ-005 SHALL have port cpu_stall, output, 1: the pipeline holds its request while this is high.
REQ-006 SHALL have ports mem_addr (out 32), mem_write_data (out 32), mem_memwrite (out 1), mem_memread (out 1) and mem_sign_mask (out 4), which drive the data memory.
REQ-007 SHALL have port mem_clk_stall, input, 1: data memory busy.

Function
REQ-008 SHALL hold up to DEPTH entries {addr[31:0], data[31:0], sign_mask[3:0]} in FIFO order.
REQ-009 SHALL push the cpu request on the clock edge when cpu_memwrite=1, cpu_memread=0 and the buffer is not full; cpu_stall=0 that cycle.
REQ-010 SHALL drive cpu_stall=1 combinationally for a store while count==DEPTH, including in a cycle where a pop occurs; the store pushes on the first edge with count<DEPTH at cycle start.
REQ-011 SHALL detect a load hazard when cpu_memread=1 and any valid entry has addr[31:2]==cpu_addr[31:2].
REQ-012 SHALL drive cpu_stall=1 for a load while a hazard exists; draining continues during the stall.
REQ-013 SHALL pass a hazard-free load straight through in the same cycle with mem_memread=1, mem_addr=cpu_addr and mem_sign_mask=cpu_sign_mask; no store is drained that cycle, so loads have priority.
REQ-014 SHALL drain the head entry when no load is passed through, count>0 and mem_clk_stall=0, as follows:
- drive mem_memwrite=1 with the head addr, data and sign_mask;
- pop the entry on that edge.
REQ-015 SHALL drive mem_memwrite=0 and mem_memread=0 when idle; mem_addr, mem_write_data and mem_sign_mask then show the head entry (zero when empty).
REQ-016 SHALL give store latency as follows: a store pushed at edge N into an empty buffer, with no load pending, appears on the mem port in cycle N+1.
REQ-017 SHALL treat cpu_memwrite=1 and cpu_memread=1 together as a load only; the store is discarded.
REQ-018 SHALL never assert mem_memwrite and mem_memread in the same cycle.
REQ-019 SHALL wrap the read and write pointers modulo DEPTH, with count in 0..DEPTH.
REQ-020 SHALL pass stores to the LED address 0x2000 through the buffer in order, like any other store.

Reset
REQ-021 SHALL, while reset=1, clear count and both pointers and invalidate all entries.
REQ-022 SHALL, while reset=1, force cpu_stall=0, mem_memwrite=0 and mem_memread=0.
REQ-023 SHALL discard buffered stores when reset is asserted mid-operation; no write is issued on that edge.

Configuration
REQ-024 SHALL, when STORE_BUFFER_STATS_EN is defined, add output stall_count[31:0]:
- counts cycles with cpu_stall=1;
- saturates at 0xFFFFFFFF;
- is cleared by reset.
REQ-025 SHALL, when STORE_BUFFER_STATS_EN is undefined, have no stall_count port or counter logic; all other behaviour is identical.

Structure
REQ-026 SHALL take the following constants from shared package store_buffer_pkg:
- default DEPTH;
- LED address 0x2000;
- sign_mask bit indices (3 = signed, 2 = word, 1 = half, 0 = byte).
REQ-027 SHALL implement entry storage, pointers and count in one sub-module, store_buffer_fifo; hazard compare and port muxing stay in store_buffer.

Verification
REQ-028 Single store: SW 0xDEADBEEF to 0x1004 at edge 0, buffer empty -> cycle 1 mem_memwrite=1, mem_addr=0x1004, mem_write_data=0xDEADBEEF; count 0 after edge 1.
REQ-029 Full: DEPTH=4, mem_clk_stall=1, 5 stores -> 5th sees cpu_stall=1; releasing mem_clk_stall -> 5th accepted on the edge after the first pop; all 5 drain in order.
REQ-030 Hazard: pending store to 0x1008, load from 0x100A -> cpu_stall=1 until the store drains, then mem_memread=1 with mem_addr=0x100A.
REQ-031 No hazard: 2 pending stores, load from 0x1100 -> same cycle mem_memread=1, mem_memwrite=0; drain resumes next cycle.
REQ-032 Reset mid-operation: 3 pending stores, reset for 1 cycle -> no mem_memwrite afterwards, cpu_stall=0, count=0.
REQ-033 Stats (STORE_BUFFER_STATS_EN defined): 3 stall cycles -> stall_count=3; reset -> 0.
